// File: rtl/sad_search_engine_pkg.sv
// me_pkg: shared types and width helpers for the SAD motion-search engine.
//   clog2   - constant function used to derive address / vector widths
//   stateT  - engine FSM states
//   pixTagT - per-read tag that travels alongside each memory read
package me_pkg;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} stateT;

   typedef struct packed {
      logic valid;
      logic first;   // pixel (0,0) of a candidate: accumulator restarts
      logic last;    // final pixel of a candidate: SAD is complete
   } pixTagT;

endpackage

// File: rtl/sad_search_engine_if.sv
// Host/memory side bus of the SAD search engine.
//   start, early_term_en        host -> engine (level start, ET sampled at accept)
//   addr_r/r_data, addr_s/s_data engine <-> reference / search memories (1-cycle read)
//   best_dist, motion_x/y       result of the last completed search
//   busy, completed             status
// master: the engine.  slave: host plus memories.
interface sad_search_engine_if
   import me_pkg::*;
#(
   parameter int BLK   = 16,
   parameter int RANGE = 16,
   parameter int PIX_W = 8
);
   localparam int WIN    = BLK + RANGE - 1;
   localparam int DIST_W = PIX_W + 2 * clog2(BLK);
   localparam int AR_W   = clog2(BLK * BLK);
   localparam int AS_W   = clog2(WIN * WIN);
   localparam int MV_W   = clog2(RANGE);

   logic              start;
   logic              early_term_en;
   logic [AR_W-1:0]   addr_r;
   logic [PIX_W-1:0]  r_data;
   logic [AS_W-1:0]   addr_s;
   logic [PIX_W-1:0]  s_data;
   logic [DIST_W-1:0] best_dist;
   logic [MV_W-1:0]   motion_x;
   logic [MV_W-1:0]   motion_y;
   logic              busy;
   logic              completed;

   modport master (
      input  start, early_term_en, r_data, s_data,
      output addr_r, addr_s, best_dist, motion_x, motion_y, busy, completed
   );

   modport slave (
      output start, early_term_en, r_data, s_data,
      input  addr_r, addr_s, best_dist, motion_x, motion_y, busy, completed
   );

endinterface

// File: rtl/sad_search_engine_accumulator.sv
// sad_accumulator: per-read SAD datapath.
//   tag/cand       tag and candidate index aligned with rData/sData
//   clear          new search accepted: forget the running best
//   abort          combinational: current candidate cannot beat the best
//   bestDist/Cand  running best (strictly-less replacement)
module sad_accumulator
   import me_pkg::*;
#(
   parameter int PIX_W  = 8,
   parameter int DIST_W = 16,
   parameter int CAND_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              etEn,
   input  pixTagT            tag,
   input  logic [CAND_W-1:0] cand,
   input  logic [PIX_W-1:0]  rData,
   input  logic [PIX_W-1:0]  sData,
   output logic              abort,
   output logic [DIST_W-1:0] bestDist,
   output logic [CAND_W-1:0] bestCand
);
   logic [PIX_W-1:0]  diff;
   logic [DIST_W-1:0] acc;
   logic [DIST_W-1:0] sum;
   logic              bestValid;

   always_comb begin
      diff  = (rData > sData) ? rData - sData : sData - rData;
      sum   = (tag.first ? '0 : acc) + DIST_W'(diff);
      // Never abort on the last pixel: the read behind it already belongs
      // to the next candidate. bestValid keeps candidate (0,0) intact.
      abort = etEn && bestValid && tag.valid && !tag.last && (sum >= bestDist);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc       <= '0;
         bestDist  <= '0;
         bestCand  <= '0;
         bestValid <= 1'b0;
      end else if (clear) begin
         bestValid <= 1'b0;
      end else if (tag.valid) begin
         acc <= sum;
         if (tag.last && (!bestValid || sum < bestDist)) begin
            bestDist  <= sum;
            bestCand  <= cand;
            bestValid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/sad_search_engine.sv
// sad_search_engine: full-search block matching over RANGE x RANGE candidates.
//   clock, reset  rising-edge clock, async active-high reset
//   bus           sad_search_engine_if.master (handshake, memory ports, result)
// One R/S address pair per cycle from a single raster counter {dy,dx,py,px}.
// Reads are tagged in stage A (with the address) and stage B (with the data).
module sad_search_engine
   import me_pkg::*;
#(
   parameter int BLK   = 16,
   parameter int RANGE = 16,
   parameter int PIX_W = 8
) (
   input logic                  clock,
   input logic                  reset,
   sad_search_engine_if.master  bus
);
   localparam int WIN    = BLK + RANGE - 1;
   localparam int LB     = clog2(BLK);
   localparam int MV_W   = clog2(RANGE);
   localparam int DIST_W = PIX_W + 2 * LB;
   localparam int AS_W   = clog2(WIN * WIN);
   localparam int PIX_N  = 2 * LB;      // {py,px}
   localparam int CAND_W = 2 * MV_W;    // {dy,dx}
   localparam int CNT_W  = CAND_W + PIX_N;

   stateT             state;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  selCnt;
   logic [CAND_W-1:0] candA;
   logic [CAND_W-1:0] candB;
   logic [CAND_W-1:0] candNext;
   pixTagT            tagA;
   pixTagT            tagB;
   logic              etEn;
   logic              abort;
   logic              newSearch;
   logic              issue;
   logic [LB-1:0]     selPx;
   logic [LB-1:0]     selPy;
   logic [MV_W-1:0]   selDx;
   logic [MV_W-1:0]   selDy;
   logic [AS_W-1:0]   addrSNext;
   logic [DIST_W-1:0] bestDist;
   logic [CAND_W-1:0] bestCand;

   always_comb begin
      candNext  = candB + CAND_W'(1);
      newSearch = (state == IDLE || state == DONE) && bus.start;
      // On abort the scan restarts at pixel 0 of the candidate after the
      // abandoned one, which may differ from where cnt has already moved.
      selCnt    = abort ? {candNext, {PIX_N{1'b0}}} : cnt;
      issue     = (state == RUN) && !(abort && (&candB));
      {selDy, selDx, selPy, selPx} = selCnt;
      addrSNext = AS_W'((int'(selDy) + int'(selPy)) * WIN + int'(selDx) + int'(selPx));
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         candA         <= '0;
         candB         <= '0;
         tagA          <= '0;
         tagB          <= '0;
         etEn          <= 1'b0;
         bus.addr_r    <= '0;
         bus.addr_s    <= '0;
         bus.best_dist <= '0;
         bus.motion_x  <= '0;
         bus.motion_y  <= '0;
         bus.busy      <= 1'b0;
         bus.completed <= 1'b0;
      end else begin
         // The read in flight during an abort belongs to the dropped candidate.
         tagB  <= abort ? '0 : tagA;
         candB <= candA;
         tagA  <= '0;
         if (issue) begin
            bus.addr_r <= selCnt[PIX_N-1:0];
            bus.addr_s <= addrSNext;
            tagA       <= '{valid: 1'b1, first: ~|selCnt[PIX_N-1:0], last: &selCnt[PIX_N-1:0]};
            candA      <= selCnt[CNT_W-1:PIX_N];
            cnt        <= selCnt + CNT_W'(1);
         end
         unique case (state)
            IDLE, DONE: if (bus.start) begin
               state         <= RUN;
               cnt           <= '0;
               etEn          <= bus.early_term_en;
               bus.busy      <= 1'b1;
               bus.completed <= 1'b0;
            end
            RUN: if (!issue || (&selCnt)) state <= DRAIN;
            // Empty pipeline means the last compare has updated the best.
            DRAIN: if (!tagA.valid && !tagB.valid) begin
               state         <= DONE;
               bus.busy      <= 1'b0;
               bus.completed <= 1'b1;
               bus.best_dist <= bestDist;
               {bus.motion_y, bus.motion_x} <= bestCand;
            end
            default: state <= IDLE;
         endcase
      end
   end

   sad_accumulator #(
      .PIX_W  (PIX_W),
      .DIST_W (DIST_W),
      .CAND_W (CAND_W)
   ) sadAcc (
      .clock    (clock),
      .reset    (reset),
      .clear    (newSearch),
      .etEn     (etEn),
      .tag      (tagB),
      .cand     (candB),
      .rData    (bus.r_data),
      .sData    (bus.s_data),
      .abort    (abort),
      .bestDist (bestDist),
      .bestCand (bestCand)
   );

endmodule

// File: tb/tb_sad_search_engine.sv
// Bench for sad_search_engine: three instances (16/16, 16/2, 4/4) share one
// pair of behavioural memories; only one instance searches at a time.
module tb_sad_search_engine;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0] mR [0:255];
   logic [7:0] mS [0:1023];

   int cfgBlk [3] = '{16, 16, 4};
   int cfgRng [3] = '{16, 2, 4};

   int offD, offX, offY;   // ET-off result on scenario-1 data

   sad_search_engine_if #(.BLK(16), .RANGE(16), .PIX_W(8)) ifA ();
   sad_search_engine_if #(.BLK(16), .RANGE(2),  .PIX_W(8)) ifB ();
   sad_search_engine_if #(.BLK(4),  .RANGE(4),  .PIX_W(8)) ifC ();

   sad_search_engine #(.BLK(16), .RANGE(16), .PIX_W(8)) dutA (.clock(clk), .reset(rst), .bus(ifA.master));
   sad_search_engine #(.BLK(16), .RANGE(2),  .PIX_W(8)) dutB (.clock(clk), .reset(rst), .bus(ifB.master));
   sad_search_engine #(.BLK(4),  .RANGE(4),  .PIX_W(8)) dutC (.clock(clk), .reset(rst), .bus(ifC.master));

   // synchronous-read memories, one cycle of latency
   always @(posedge clk) begin
      ifA.r_data <= mR[ifA.addr_r];
      ifA.s_data <= mS[ifA.addr_s];
      ifB.r_data <= mR[ifB.addr_r];
      ifB.s_data <= mS[ifB.addr_s];
      ifC.r_data <= mR[ifC.addr_r];
      ifC.s_data <= mS[ifC.addr_s];
   end

   task automatic drive(input int id, input bit st, input bit et);
      case (id)
         0: begin ifA.start = st; ifA.early_term_en = et; end
         1: begin ifB.start = st; ifB.early_term_en = et; end
         default: begin ifC.start = st; ifC.early_term_en = et; end
      endcase
   endtask

   function automatic bit doneOf(input int id);
      case (id)
         0: return ifA.completed;
         1: return ifB.completed;
         default: return ifC.completed;
      endcase
   endfunction

   function automatic bit busyOf(input int id);
      case (id)
         0: return ifA.busy;
         1: return ifB.busy;
         default: return ifC.busy;
      endcase
   endfunction

   task automatic result(input int id, output int d, output int mx, output int my);
      case (id)
         0: begin d = int'(ifA.best_dist); mx = int'(ifA.motion_x); my = int'(ifA.motion_y); end
         1: begin d = int'(ifB.best_dist); mx = int'(ifB.motion_x); my = int'(ifB.motion_y); end
         default: begin d = int'(ifC.best_dist); mx = int'(ifC.motion_x); my = int'(ifC.motion_y); end
      endcase
   endtask

   // kind 0: R 0..50, S noise 200..255 with an exact copy of R at (cx,cy)
   // kind 1: all zero   kind 2: R=255, S=0   kind 3: R,S in 0..3 (many ties)
   task automatic fill(input int id, input int kind, input int cx, input int cy);
      int blk = cfgBlk[id];
      int win = cfgBlk[id] + cfgRng[id] - 1;
      for (int i = 0; i < blk * blk; i++)
         case (kind)
            0: mR[i] = 8'($urandom_range(50, 0));
            1: mR[i] = 8'd0;
            2: mR[i] = 8'd255;
            default: mR[i] = 8'($urandom_range(3, 0));
         endcase
      for (int i = 0; i < win * win; i++)
         case (kind)
            0: mS[i] = 8'($urandom_range(255, 200));
            1, 2: mS[i] = 8'd0;
            default: mS[i] = 8'($urandom_range(3, 0));
         endcase
      if (kind == 0)
         for (int py = 0; py < blk; py++)
            for (int px = 0; px < blk; px++)
               mS[(cy + py) * win + cx + px] = mR[py * blk + px];
   endtask

   // Exhaustive search straight from the definition: first minimum in raster order.
   function automatic void refModel(input int id, output int bd, output int bx, output int by);
      int blk = cfgBlk[id];
      int rng = cfgRng[id];
      int win = blk + rng - 1;
      bd = -1; bx = 0; by = 0;
      for (int dy = 0; dy < rng; dy++)
         for (int dx = 0; dx < rng; dx++) begin
            int sad = 0;
            for (int py = 0; py < blk; py++)
               for (int px = 0; px < blk; px++) begin
                  int a = int'(mR[py * blk + px]) - int'(mS[(dy + py) * win + dx + px]);
                  sad += (a < 0) ? -a : a;
               end
            if (bd < 0 || sad < bd) begin bd = sad; bx = dx; by = dy; end
         end
   endfunction

   // lat = number of edges after the accept edge until completed is seen
   task automatic runSearch(input int id, input bit et, input int budget, output int lat);
      @(negedge clk); drive(id, 1'b1, et);
      @(posedge clk); #1; drive(id, 1'b0, et);
      lat = 0;
      while (!doneOf(id) && lat < budget) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic test_reset();
      int d, mx, my;
      rst = 1'b1;
      for (int id = 0; id < 3; id++) drive(id, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      for (int id = 0; id < 3; id++) begin
         result(id, d, mx, my);
         checks++;
         if ({d, mx, my} !== {32'd0, 32'd0, 32'd0}) begin
            errors++; $display("FAIL reset_result id%0d: got %0d/%0d/%0d want 0/0/0", id, d, mx, my);
         end
         checks++;
         if ({busyOf(id), doneOf(id)} !== 2'b00) begin
            errors++; $display("FAIL reset_status id%0d: got busy=%0b done=%0b want 0/0", id, busyOf(id), doneOf(id));
         end
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_zero();
      int lat, d, mx, my, bd, bx, by;
      fill(0, 1, 0, 0);
      refModel(0, bd, bx, by);
      runSearch(0, 1'b1, 70000, lat);
      result(0, d, mx, my);
      checks++;
      if (!doneOf(0)) begin errors++; $display("FAIL zero_timeout: got lat=%0d want completion", lat); end
      checks++;
      if ({d, mx, my} !== {bd, bx, by}) begin
         errors++; $display("FAIL zero_result: got %0d/%0d/%0d want %0d/%0d/%0d", d, mx, my, bd, bx, by);
      end
   endtask

   task automatic test_latency();
      int lat, d, mx, my, bd, bx, by;
      int want;
      bit busyDrop;
      want = 16 * 16 * 16 * 16 + 3;
      fill(0, 0, 5, 3);
      refModel(0, bd, bx, by);
      @(negedge clk); drive(0, 1'b1, 1'b0);
      @(posedge clk); #1; drive(0, 1'b0, 1'b0);
      checks++;
      if ({busyOf(0), doneOf(0)} !== 2'b10) begin
         errors++; $display("FAIL lat_accept: got busy=%0b done=%0b want 1/0", busyOf(0), doneOf(0));
      end
      lat = 0;
      busyDrop = 1'b0;
      while (!doneOf(0) && lat < 70000) begin
         @(posedge clk); #1; lat++;
         if (lat == 500) drive(0, 1'b1, 1'b1);   // start while busy must be ignored
         if (lat == 501) drive(0, 1'b0, 1'b0);
         if (!doneOf(0) && !busyOf(0)) busyDrop = 1'b1;
      end
      checks++;
      if (lat !== want) begin errors++; $display("FAIL lat_cycles: got %0d want %0d", lat, want); end
      checks++;
      if (busyDrop || busyOf(0)) begin
         errors++; $display("FAIL lat_busy: got drop=%0b busy_at_end=%0b want 0/0", busyDrop, busyOf(0));
      end
      result(0, d, mx, my);
      checks++;
      if ({d, mx, my} !== {bd, bx, by}) begin
         errors++; $display("FAIL copy_result: got %0d/%0d/%0d want %0d/%0d/%0d", d, mx, my, bd, bx, by);
      end
      offD = bd; offX = bx; offY = by;
   endtask

   task automatic test_early_term();
      int lat, d, mx, my;
      runSearch(0, 1'b1, 70000, lat);
      result(0, d, mx, my);
      checks++;
      if ({d, mx, my} !== {offD, offX, offY}) begin
         errors++; $display("FAIL et_result: got %0d/%0d/%0d want %0d/%0d/%0d", d, mx, my, offD, offX, offY);
      end
      checks++;
      if (!doneOf(0) || lat >= 65539) begin
         errors++; $display("FAIL et_cycles: got %0d done=%0b want <65539 done=1", lat, doneOf(0));
      end
   endtask

   task automatic test_mid_reset();
      int lat, d, mx, my, bd, bx, by;
      @(negedge clk); drive(0, 1'b1, 1'b0);
      @(posedge clk); #1; drive(0, 1'b0, 1'b0);
      repeat (999) @(posedge clk);
      #1;
      result(0, d, mx, my);
      checks++;
      if ({d, mx, my, 31'd0, busyOf(0)} !== {offD, offX, offY, 32'd1}) begin
         errors++; $display("FAIL hold_result: got %0d/%0d/%0d busy=%0b want %0d/%0d/%0d busy=1",
                            d, mx, my, busyOf(0), offD, offX, offY);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      result(0, d, mx, my);
      checks++;
      if ({d, mx, my} !== {32'd0, 32'd0, 32'd0} || {busyOf(0), doneOf(0)} !== 2'b00 ||
          ifA.addr_r !== 8'd0 || ifA.addr_s !== 10'd0) begin
         errors++; $display("FAIL midreset_outputs: got %0d/%0d/%0d busy=%0b done=%0b ar=%0d as=%0d want all 0",
                            d, mx, my, busyOf(0), doneOf(0), ifA.addr_r, ifA.addr_s);
      end
      @(negedge clk); rst = 1'b0;
      fill(0, 0, 2, 0);
      refModel(0, bd, bx, by);
      runSearch(0, 1'b1, 70000, lat);
      result(0, d, mx, my);
      checks++;
      if (!doneOf(0) || {d, mx, my} !== {bd, bx, by}) begin
         errors++; $display("FAIL restart_result: got %0d/%0d/%0d done=%0b want %0d/%0d/%0d",
                            d, mx, my, doneOf(0), bd, bx, by);
      end
   endtask

   task automatic test_saturated();
      int lat, d, mx, my;
      fill(1, 2, 0, 0);
      runSearch(1, 1'b1, 5000, lat);
      result(1, d, mx, my);
      checks++;
      if ({d, mx, my} !== {32'd65280, 32'd0, 32'd0}) begin
         errors++; $display("FAIL sat_result: got %0d/%0d/%0d want 65280/0/0", d, mx, my);
      end
      checks++;
      if (lat !== 16 * 16 * 2 * 2 + 3) begin
         errors++; $display("FAIL sat_cycles: got %0d want %0d", lat, 16 * 16 * 2 * 2 + 3);
      end
   endtask

   task automatic test_small();
      int lat, d, mx, my, bd, bx, by;
      fill(2, 0, 1, 2);
      refModel(2, bd, bx, by);
      runSearch(2, 1'b0, 2000, lat);
      result(2, d, mx, my);
      checks++;
      if ({d, mx, my} !== {bd, bx, by}) begin
         errors++; $display("FAIL small_result: got %0d/%0d/%0d want %0d/%0d/%0d", d, mx, my, bd, bx, by);
      end
      checks++;
      if (lat !== 4 * 4 * 4 * 4 + 3) begin
         errors++; $display("FAIL small_cycles: got %0d want %0d", lat, 4 * 4 * 4 * 4 + 3);
      end
   endtask

   task automatic test_random_ties();
      int lat, d, mx, my, bd, bx, by;
      for (int t = 0; t < 8; t++) begin
         bit et = t[0];
         fill(2, 3, 0, 0);
         refModel(2, bd, bx, by);
         runSearch(2, et, 2000, lat);
         result(2, d, mx, my);
         checks++;
         if ({d, mx, my} !== {bd, bx, by}) begin
            errors++; $display("FAIL rand_result t%0d et%0b: got %0d/%0d/%0d want %0d/%0d/%0d",
                               t, et, d, mx, my, bd, bx, by);
         end
         checks++;
         if (!doneOf(2) || (et ? (lat > 259) : (lat !== 259))) begin
            errors++; $display("FAIL rand_cycles t%0d et%0b: got %0d want %s259", t, et, lat, et ? "<=" : "");
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_latency();
      test_early_term();
      test_mid_reset();
      test_saturated();
      test_small();
      test_random_ties();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
